// File: rtl/tl_pkg.sv
// Shared types and constants for the intersection scheduler: state codes, lamp encodings and
// default phase durations (in ticks).
package tl_pkg;

  typedef enum logic [2:0] {
    StAllRed = 3'd0,
    StNsG    = 3'd1,
    StNsY    = 3'd2,
    StEwG    = 3'd3,
    StEwY    = 3'd4,
    StWalk   = 3'd5
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int unsigned DEF_T_GREEN_MIN = 10;
  localparam int unsigned DEF_T_GREEN_MAX = 30;
  localparam int unsigned DEF_T_YELLOW    = 3;
  localparam int unsigned DEF_T_ALLRED    = 2;
  localparam int unsigned DEF_T_WALK      = 8;

  // Returns {ns_light, ew_light, walk}; anything not a legal phase shows all red.
  function automatic logic [6:0] lamp_decode(input state_e s);
    unique case (s)
      StNsG:   lamp_decode = {LAMP_GRN, LAMP_RED, 1'b0};
      StNsY:   lamp_decode = {LAMP_YEL, LAMP_RED, 1'b0};
      StEwG:   lamp_decode = {LAMP_RED, LAMP_GRN, 1'b0};
      StEwY:   lamp_decode = {LAMP_RED, LAMP_YEL, 1'b0};
      StWalk:  lamp_decode = {LAMP_RED, LAMP_RED, 1'b1};
      default: lamp_decode = {LAMP_RED, LAMP_RED, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Tick counter for the current phase: counts enabled ticks, clears synchronously and holds at
// a caller-supplied saturation value.
module tl_phase_timer #(
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          clr,
  input  logic [CW-1:0] sat,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (tick && (cnt_q < sat)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tl_intersection_scheduler.sv
// Actuated NS/EW intersection scheduler with a latched pedestrian walk phase; lamps and debug
// phase are registered from the next state so they change on the same edge as the state.
module tl_intersection_scheduler
  import tl_pkg::*;
#(
  parameter int unsigned T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int unsigned T_GREEN_MAX = DEF_T_GREEN_MAX,
  parameter int unsigned T_YELLOW    = DEF_T_YELLOW,
  parameter int unsigned T_ALLRED    = DEF_T_ALLRED,
  parameter int unsigned T_WALK      = DEF_T_WALK,
  parameter int unsigned CW          = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [CW-1:0] GMinM1   = CW'(T_GREEN_MIN - 1);
  localparam logic [CW-1:0] GMaxM1   = CW'(T_GREEN_MAX - 1);
  localparam logic [CW-1:0] YelM1    = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] AllRedM1 = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] WalkM1   = CW'(T_WALK - 1);

  state_e        state_q, state_d;
  logic          last_q, ped_pend_q, after_walk_q;
  logic [CW-1:0] cnt, sat;
  logic          ns_exit, ew_exit, enter_walk, enter_green;

  // A green yields only to real demand: early if its own detector is idle, otherwise at max.
  assign ns_exit = tick && (req_ew || ped_pend_q) &&
                   (((cnt >= GMinM1) && !req_ns) || (cnt >= GMaxM1));
  assign ew_exit = tick && (req_ns || ped_pend_q) &&
                   (((cnt >= GMinM1) && !req_ew) || (cnt >= GMaxM1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAllRed: begin
        if (tick && (cnt == AllRedM1)) begin
          if (ped_pend_q && !after_walk_q) state_d = StWalk;
          else if (req_ns ^ req_ew)        state_d = req_ns ? StNsG : StEwG;
          else                             state_d = last_q ? StNsG : StEwG;
        end
      end
      StNsG:   if (ns_exit) state_d = StNsY;
      StNsY:   if (tick && (cnt == YelM1)) state_d = StAllRed;
      StEwG:   if (ew_exit) state_d = StEwY;
      StEwY:   if (tick && (cnt == YelM1)) state_d = StAllRed;
      StWalk:  if (tick && (cnt == WalkM1)) state_d = StAllRed;
      default: state_d = StAllRed;
    endcase
  end

  assign enter_walk  = (state_d == StWalk) && (state_q != StWalk);
  assign enter_green = ((state_d == StNsG) || (state_d == StEwG)) && (state_d != state_q);
  // Resting greens hold the counter at max-1 so a late request can still cut in immediately.
  assign sat = ((state_q == StNsG) || (state_q == StEwG)) ? GMaxM1 : '1;

  tl_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .clr  (state_d != state_q),
    .sat  (sat),
    .cnt  (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StAllRed;
      last_q       <= 1'b1;
      ped_pend_q   <= 1'b0;
      after_walk_q <= 1'b0;
      ns_light     <= LAMP_RED;
      ew_light     <= LAMP_RED;
      walk         <= 1'b0;
      ped_ack      <= 1'b0;
      phase        <= 3'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == StNsY) && (state_d == StAllRed)) last_q <= 1'b0;
      if ((state_q == StEwY) && (state_d == StAllRed)) last_q <= 1'b1;
      if (enter_walk)   ped_pend_q <= 1'b0;
      else if (ped_req) ped_pend_q <= 1'b1;
      if ((state_q == StWalk) && (state_d == StAllRed)) after_walk_q <= 1'b1;
      else if (enter_green)                             after_walk_q <= 1'b0;
      {ns_light, ew_light, walk} <= lamp_decode(state_d);
      ped_ack <= enter_walk;
      phase   <= state_d;
    end
  end

endmodule

// File: tb/tb_tl_intersection_scheduler.sv
// Directed bench for tl_intersection_scheduler with hand-computed phase sequences.
module tb_tl_intersection_scheduler;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk = 1'b0;
  logic       rst, tick, req_ns, req_ew, ped_req;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, ped_ack;

  int unsigned errors = 0;
  int unsigned checks = 0;

  tl_intersection_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .req_ns   (req_ns),
    .req_ew   (req_ew),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .ped_ack  (ped_ack),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares {phase, ns_light, ew_light, walk} in one go.
  task automatic chk_lamps(input string tag, input logic [2:0] ph, input logic [2:0] ns,
                           input logic [2:0] ew, input logic wk);
    chk(tag, {phase, ns_light, ew_light, walk}, {ph, ns, ew, wk});
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; req_ns = 1'b0; req_ew = 1'b0; ped_req = 1'b0;
    step(2);
    rst = 1'b0;
    chk_lamps("reset_lamps", 3'd0, RED, RED, 1'b0);
    chk("reset_ack", 10'(ped_ack), 10'd0);
    chk("reset_last", 10'(dut.last_q), 10'd1);
    chk("reset_pend", 10'(dut.ped_pend_q), 10'd0);
    step(1); chk_lamps("allred_2nd", 3'd0, RED, RED, 1'b0);
    step(1); chk_lamps("ns_first", 3'd1, GRN, RED, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1); chk_lamps("ns_rest", 3'd1, GRN, RED, 1'b0);
    end

    // EW request against a saturated NS green.
    req_ew = 1'b1;
    step(1); chk_lamps("ns_y", 3'd2, YEL, RED, 1'b0);
    step(2); chk_lamps("ns_y_hold", 3'd2, YEL, RED, 1'b0);
    step(1); chk_lamps("allred_a", 3'd0, RED, RED, 1'b0);
    chk("last_ns", 10'(dut.last_q), 10'd0);
    step(1); chk_lamps("allred_b", 3'd0, RED, RED, 1'b0);
    step(1); chk_lamps("ew_g", 3'd3, RED, GRN, 1'b0);

    // Both detectors held: max-green alternation.
    req_ns = 1'b1;
    step(29); chk_lamps("ew_max_hold", 3'd3, RED, GRN, 1'b0);
    step(1);  chk_lamps("ew_y_max", 3'd4, RED, YEL, 1'b0);
    step(3);  chk_lamps("allred_c", 3'd0, RED, RED, 1'b0);
    chk("last_ew", 10'(dut.last_q), 10'd1);
    step(2);  chk_lamps("ns_g_alt", 3'd1, GRN, RED, 1'b0);
    step(29); chk_lamps("ns_max_hold", 3'd1, GRN, RED, 1'b0);
    step(1);  chk_lamps("ns_y_max", 3'd2, YEL, RED, 1'b0);
    step(3);  chk_lamps("allred_d", 3'd0, RED, RED, 1'b0);
    step(2);  chk_lamps("ew_g_alt", 3'd3, RED, GRN, 1'b0);
    req_ns = 1'b0; req_ew = 1'b0;

    // Single pedestrian pulse during NS green.
    rst = 1'b1;
    step(1); rst = 1'b0;
    chk_lamps("reset2", 3'd0, RED, RED, 1'b0);
    step(2); chk_lamps("ns_g_ped", 3'd1, GRN, RED, 1'b0);
    ped_req = 1'b1;
    step(1); ped_req = 1'b0;
    chk("pend_set", 10'(dut.ped_pend_q), 10'd1);
    step(8); chk_lamps("ns_min_hold", 3'd1, GRN, RED, 1'b0);
    step(1); chk_lamps("ns_y_ped", 3'd2, YEL, RED, 1'b0);
    step(3); chk_lamps("allred_e", 3'd0, RED, RED, 1'b0);
    step(2); chk_lamps("walk_in", 3'd5, RED, RED, 1'b1);
    chk("ack_first", 10'(ped_ack), 10'd1);
    chk("pend_clr", 10'(dut.ped_pend_q), 10'd0);
    step(1); chk("ack_second", 10'(ped_ack), 10'd0);
    chk_lamps("walk_2nd", 3'd5, RED, RED, 1'b1);
    step(6); chk_lamps("walk_last", 3'd5, RED, RED, 1'b1);
    step(1); chk_lamps("walk_out", 3'd0, RED, RED, 1'b0);
    step(2); chk_lamps("ew_after_walk", 3'd3, RED, GRN, 1'b0);

    // ped_req high on the cycle whose edge enters WALK.
    ped_req = 1'b1;
    step(1); ped_req = 1'b0;
    step(9); chk_lamps("ew_y_ped", 3'd4, RED, YEL, 1'b0);
    step(3); chk_lamps("allred_f", 3'd0, RED, RED, 1'b0);
    step(1); chk_lamps("allred_g", 3'd0, RED, RED, 1'b0);
    ped_req = 1'b1;
    step(1); ped_req = 1'b0;
    chk_lamps("walk_in2", 3'd5, RED, RED, 1'b1);
    chk("ack_in2", 10'(ped_ack), 10'd1);
    chk("pend_clr_wins", 10'(dut.ped_pend_q), 10'd0);
    step(7); chk_lamps("walk_last2", 3'd5, RED, RED, 1'b1);
    step(1); chk_lamps("allred_h", 3'd0, RED, RED, 1'b0);
    step(2); chk_lamps("ns_after_walk", 3'd1, GRN, RED, 1'b0);
    chk("pend_still_clr", 10'(dut.ped_pend_q), 10'd0);
    step(15); chk_lamps("no_second_walk", 3'd1, GRN, RED, 1'b0);

    // No tick: phase frozen despite demand.
    req_ew = 1'b1; tick = 1'b0;
    step(50); chk_lamps("tick_low", 3'd1, GRN, RED, 1'b0);
    tick = 1'b1;
    step(1); chk_lamps("tick_resume", 3'd2, YEL, RED, 1'b0);
    step(3); chk_lamps("allred_i", 3'd0, RED, RED, 1'b0);
    step(2); chk_lamps("ew_g2", 3'd3, RED, GRN, 1'b0);
    req_ew = 1'b0; req_ns = 1'b1;
    step(9); chk_lamps("ew_min_hold", 3'd3, RED, GRN, 1'b0);
    step(1); chk_lamps("ew_y_min", 3'd4, RED, YEL, 1'b0);
    step(1);
    tick = 1'b0; rst = 1'b1;
    step(1); rst = 1'b0;
    chk_lamps("rst_mid_ew_y", 3'd0, RED, RED, 1'b0);
    chk("rst_last", 10'(dut.last_q), 10'd1);

    // ped_req latched with tick low, served once ticks resume.
    req_ns = 1'b0; ped_req = 1'b1;
    step(1); ped_req = 1'b0;
    step(5);
    chk("pend_no_tick", 10'(dut.ped_pend_q), 10'd1);
    chk_lamps("allred_no_tick", 3'd0, RED, RED, 1'b0);
    tick = 1'b1;
    step(2); chk_lamps("walk_in3", 3'd5, RED, RED, 1'b1);
    chk("ack_in3", 10'(ped_ack), 10'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
